// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// A flush or a load-use hazard loads a NOP bubble into EX; bubbles are counted (saturating).
module id_ex_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic        i_inst_vld,
    input  logic        i_rd_wren,
    input  logic        i_br_un,
    input  logic        i_asel,
    input  logic        i_bsel,
    input  logic [3:0]  i_alu_op,
    input  logic        i_wren,
    input  logic [2:0]  i_slt_sl,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_ex_inst,
    output logic [31:0] o_ex_pc,
    output logic [31:0] o_ex_rs1_data,
    output logic [31:0] o_ex_rs2_data,
    output logic [31:0] o_ex_imm,
    output logic [4:0]  o_ex_rs1_addr,
    output logic [4:0]  o_ex_rs2_addr,
    output logic [4:0]  o_ex_rd_addr,
    output logic        o_ex_inst_vld,
    output logic        o_ex_rd_wren,
    output logic        o_ex_br_un,
    output logic        o_ex_asel,
    output logic        o_ex_bsel,
    output logic [3:0]  o_ex_alu_op,
    output logic        o_ex_wren,
    output logic [2:0]  o_ex_slt_sl,
    output logic [1:0]  o_ex_wb_sel,
    output logic [15:0] o_bubble_cnt
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        inst_vld;
        logic        rd_wren;
        logic        br_un;
        logic        asel;
        logic        bsel;
        logic [3:0]  alu_op;
        logic        wren;
        logic [2:0]  slt_sl;
        logic [1:0]  wb_sel;
    } ex_t;

    localparam ex_t BUBBLE = '{inst: 32'h0000_0013, default: '0};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ex_t         ex_d, ex_q;
    logic [15:0] cnt_d, cnt_q;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used, ex_is_load, hazard, load_bubble;

    always_comb begin
        opcode   = i_inst[6:0];
        rs1      = i_inst[19:15];
        rs2      = i_inst[24:20];
        rd       = i_inst[11:7];
        rs1_used = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
        rs2_used = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};

        // wb_sel 00 selects memory data, so this EX entry's result is not ready until MEM
        ex_is_load = ex_q.rd_wren && (ex_q.wb_sel == 2'b00) && (ex_q.rd_addr != 5'd0);
        hazard     = ex_is_load &&
                     ((rs1_used && (rs1 != 5'd0) && (rs1 == ex_q.rd_addr)) ||
                      (rs2_used && (rs2 != 5'd0) && (rs2 == ex_q.rd_addr)));

        o_stall     = hazard && !i_flush;
        load_bubble = i_flush || hazard;

        ex_d = '{inst: i_inst, pc: i_pc, rs1_data: i_rs1_data, rs2_data: i_rs2_data,
                 imm: i_imm, rs1_addr: rs1, rs2_addr: rs2, rd_addr: rd,
                 inst_vld: i_inst_vld, rd_wren: i_rd_wren, br_un: i_br_un,
                 asel: i_asel, bsel: i_bsel, alu_op: i_alu_op, wren: i_wren,
                 slt_sl: i_slt_sl, wb_sel: i_wb_sel};
        cnt_d = cnt_q;
        if (load_bubble) begin
            ex_d  = BUBBLE;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex_q  <= BUBBLE;
            cnt_q <= 16'd0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_ex_inst     = ex_q.inst;
    assign o_ex_pc       = ex_q.pc;
    assign o_ex_rs1_data = ex_q.rs1_data;
    assign o_ex_rs2_data = ex_q.rs2_data;
    assign o_ex_imm      = ex_q.imm;
    assign o_ex_rs1_addr = ex_q.rs1_addr;
    assign o_ex_rs2_addr = ex_q.rs2_addr;
    assign o_ex_rd_addr  = ex_q.rd_addr;
    assign o_ex_inst_vld = ex_q.inst_vld;
    assign o_ex_rd_wren  = ex_q.rd_wren;
    assign o_ex_br_un    = ex_q.br_un;
    assign o_ex_asel     = ex_q.asel;
    assign o_ex_bsel     = ex_q.bsel;
    assign o_ex_alu_op   = ex_q.alu_op;
    assign o_ex_wren     = ex_q.wren;
    assign o_ex_slt_sl   = ex_q.slt_sl;
    assign o_ex_wb_sel   = ex_q.wb_sel;
    assign o_bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID vectors push the expected EX entry,
// a monitor pops and compares after each rising edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, pc, rs1d, rs2d, imm;
    logic        vld, rd_wren, br_un, asel, bsel, wren, flush;
    logic [3:0]  alu_op;
    logic [2:0]  slt;
    logic [1:0]  wb;
    logic        stall;
    logic [31:0] e_inst, e_pc, e_rs1d, e_rs2d, e_imm;
    logic [4:0]  e_rs1a, e_rs2a, e_rda;
    logic        e_vld, e_rdw, e_brun, e_asel, e_bsel, e_wren;
    logic [3:0]  e_alu;
    logic [2:0]  e_slt;
    logic [1:0]  e_wb;
    logic [15:0] cnt;

    typedef struct packed {
        logic [31:0] inst, pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic        vld, rdw, brun, asel, bsel;
        logic [3:0]  alu;
        logic        wren;
        logic [2:0]  slt;
        logic [1:0]  wb;
        logic [15:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    obs_t act;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk(clk), .i_reset(rst), .i_inst(inst), .i_pc(pc),
        .i_rs1_data(rs1d), .i_rs2_data(rs2d), .i_imm(imm),
        .i_inst_vld(vld), .i_rd_wren(rd_wren), .i_br_un(br_un), .i_asel(asel),
        .i_bsel(bsel), .i_alu_op(alu_op), .i_wren(wren), .i_slt_sl(slt),
        .i_wb_sel(wb), .i_flush(flush), .o_stall(stall),
        .o_ex_inst(e_inst), .o_ex_pc(e_pc), .o_ex_rs1_data(e_rs1d),
        .o_ex_rs2_data(e_rs2d), .o_ex_imm(e_imm), .o_ex_rs1_addr(e_rs1a),
        .o_ex_rs2_addr(e_rs2a), .o_ex_rd_addr(e_rda), .o_ex_inst_vld(e_vld),
        .o_ex_rd_wren(e_rdw), .o_ex_br_un(e_brun), .o_ex_asel(e_asel),
        .o_ex_bsel(e_bsel), .o_ex_alu_op(e_alu), .o_ex_wren(e_wren),
        .o_ex_slt_sl(e_slt), .o_ex_wb_sel(e_wb), .o_bubble_cnt(cnt)
    );

    assign act = '{inst: e_inst, pc: e_pc, rs1d: e_rs1d, rs2d: e_rs2d, imm: e_imm,
                   rs1a: e_rs1a, rs2a: e_rs2a, rda: e_rda, vld: e_vld, rdw: e_rdw,
                   brun: e_brun, asel: e_asel, bsel: e_bsel, alu: e_alu, wren: e_wren,
                   slt: e_slt, wb: e_wb, cnt: cnt};

    function automatic obs_t bubble_exp(input logic [15:0] c);
        obs_t o;
        o      = '0;
        o.inst = 32'h0000_0013;
        o.cnt  = c;
        return o;
    endfunction

    function automatic obs_t capture_exp(input logic [15:0] c);
        obs_t o;
        o = '{inst: inst, pc: pc, rs1d: rs1d, rs2d: rs2d, imm: imm,
              rs1a: inst[19:15], rs2a: inst[24:20], rda: inst[11:7],
              vld: vld, rdw: rd_wren, brun: br_un, asel: asel, bsel: bsel,
              alu: alu_op, wren: wren, slt: slt, wb: wb, cnt: c};
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic check_bit(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, a, e);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] e);
        checks++;
        if (cnt !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, cnt, e);
        end
    endtask

    // Drive one ID vector; exp_bub selects bubble vs capture of that vector.
    task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] p,
                         input logic v, input logic rw, input logic [1:0] wbs,
                         input logic [3:0] op, input logic fl,
                         input logic exp_stall, input logic exp_bub,
                         input logic [15:0] exp_cnt);
        @(negedge clk);
        inst = ins; pc = p; rs1d = p + 32'h1000; rs2d = p + 32'h2000; imm = p + 32'h3000;
        vld = v; rd_wren = rw; wb = wbs; alu_op = op; flush = fl;
        br_un = ins[12]; asel = ins[13]; bsel = ins[14]; wren = ins[5]; slt = ins[14:12];
        #1;
        check_bit({name, "_stall"}, stall, exp_stall);
        exp_q.push_back(exp_bub ? bubble_exp(exp_cnt) : capture_exp(exp_cnt));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check_obs("ex_reg", act, exp_q.pop_front());
    end

    localparam logic [31:0] LW_X5  = 32'h0000_A283;
    localparam logic [31:0] ADD    = 32'h0022_8333;
    localparam logic [31:0] LW_X0  = 32'h0000_A003;
    localparam logic [31:0] ADD_X0 = 32'h0000_0333;
    localparam logic [31:0] LUI_X7 = 32'h0002_83B7;
    localparam logic [31:0] SW_X5  = 32'h0050_A023;
    localparam logic [31:0] ADDI   = 32'h0050_8413;

    initial begin
        rst = 1'b1; flush = 1'b0; inst = 32'h13; pc = '0; rs1d = '0; rs2d = '0; imm = '0;
        vld = 1'b0; rd_wren = 1'b0; br_un = 1'b0; asel = 1'b0; bsel = 1'b0;
        alu_op = '0; wren = 1'b0; slt = '0; wb = '0;
        repeat (2) @(posedge clk);
        #1;
        check_obs("reset_ex", act, bubble_exp(16'd0));
        check_bit("reset_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // name, inst, pc, vld, rd_wren, wb, alu, flush, stall, bubble, cnt
        apply("lw_a",    LW_X5,  32'h100, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd0);
        apply("add_use", ADD,    32'h104, 1, 1, 2'b01, 4'h0, 0, 1, 1, 16'd1);
        apply("add_re",  ADD,    32'h104, 1, 1, 2'b01, 4'h0, 0, 0, 0, 16'd1);
        apply("lw_x0",   LW_X0,  32'h108, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd1);
        apply("add_x0",  ADD_X0, 32'h10C, 1, 1, 2'b01, 4'h0, 0, 0, 0, 16'd1);
        apply("lw_b",    LW_X5,  32'h110, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd1);
        apply("flush_hz",ADD,    32'h114, 1, 1, 2'b01, 4'h0, 1, 0, 1, 16'd2);
        apply("lw_c",    LW_X5,  32'h200, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd2);
        apply("lui",     LUI_X7, 32'h204, 1, 1, 2'b11, 4'hF, 0, 0, 0, 16'd2);
        apply("lw_d",    LW_X5,  32'h208, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd2);
        apply("sw_use",  SW_X5,  32'h20C, 1, 0, 2'b00, 4'h0, 0, 1, 1, 16'd3);
        apply("sw_re",   SW_X5,  32'h20C, 1, 0, 2'b00, 4'h0, 0, 0, 0, 16'd3);
        apply("lw_e",    LW_X5,  32'h300, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd3);
        apply("addi",    ADDI,   32'h304, 1, 1, 2'b01, 4'h0, 0, 0, 0, 16'd3);
        apply("lw_f",    LW_X5,  32'h308, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd3);
        apply("nv_use",  ADD,    32'h30C, 0, 1, 2'b01, 4'h0, 0, 1, 1, 16'd4);
        apply("nv_re",   ADD,    32'h30C, 0, 1, 2'b01, 4'h0, 0, 0, 0, 16'd4);
        apply("lw_g",    LW_X5,  32'h400, 1, 1, 2'b00, 4'h0, 0, 0, 0, 16'd4);

        // Async reset asserted between edges while a stall is pending.
        @(negedge clk);
        inst = ADD; pc = 32'h404; vld = 1'b1; rd_wren = 1'b1; wb = 2'b01; flush = 1'b0;
        #1;
        check_bit("pre_rst_stall", stall, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_obs("async_rst_ex", act, bubble_exp(16'd0));
        check_bit("async_rst_stall", stall, 1'b0);
        rst = 1'b0;
        #1;
        exp_q.push_back(capture_exp(16'd0));

        // Saturation: 65536 flushes from zero, then one more.
        @(negedge clk);
        flush = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check_cnt("sat_cnt", 16'hFFFF);
        @(posedge clk);
        #1;
        check_cnt("sat_hold", 16'hFFFF);
        check_obs("sat_ex", act, bubble_exp(16'hFFFF));
        @(negedge clk);
        flush = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
